// File: rtl/instr_sequencer.sv
// instr_sequencer: 16-entry program buffer replayed onto the 4-bit CPU.
// Ports: load_* write the buffer; start/step_mode/step/halt control the
//   run; instruction/instr_valid/pc/busy/done report it (all registered).
module instr_sequencer #(
   parameter int IW    = 9,
   parameter int DEPTH = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_en,
   input  logic [3:0]    load_addr,
   input  logic [IW-1:0] load_data,
   input  logic [4:0]    prog_len,
   input  logic          start,
   input  logic          step_mode,
   input  logic          step,
   input  logic          halt,
   output logic [IW-1:0] instruction,
   output logic          instr_valid,
   output logic [3:0]    pc,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] prog_q [DEPTH];
   logic [IW-1:0] instr_q, instr_d;
   logic          valid_q, valid_d;
   logic [3:0]    pc_q, pc_d;
   logic [4:0]    len_q, len_d;
   logic          done_q, done_d;
   logic          we;
   logic          issue;
   logic [4:0]    pc_inc;

   // The write lands at the start edge too, so the first issue sees it.
   assign we     = load_en && !halt && (state_q != S_RUN);
   assign issue  = !step_mode || step;
   assign pc_inc = {1'b0, pc_q} + 5'd1;

   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      valid_d = 1'b0;
      pc_d    = pc_q;
      len_d   = len_q;
      done_d  = done_q;
      if (halt) begin
         state_d = S_IDLE;
         pc_d    = 4'd0;
         done_d  = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  len_d  = (prog_len > 5'd16) ? 5'd16 : prog_len;
                  pc_d   = 4'd0;
                  done_d = 1'b0;
                  if (prog_len == 5'd0) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_RUN;
                  end
               end else if (load_en) begin
                  state_d = S_IDLE;
                  done_d  = 1'b0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  instr_d = prog_q[pc_q];
                  valid_d = 1'b1;
                  pc_d    = pc_inc[3:0];
                  // pc wraps to 0 when the last word is entry 15.
                  if (pc_inc == len_q) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         valid_q <= 1'b0;
         pc_q    <= 4'd0;
         len_q   <= 5'd0;
         done_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            prog_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         pc_q    <= pc_d;
         len_q   <= len_d;
         done_q  <= done_d;
         if (we) begin
            prog_q[load_addr] <= load_data;
         end
      end
   end

   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = (state_q == S_RUN);
   assign done        = done_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program buffer and issue controller placed directly upstream of the 4-bit teaching CPU. It stores up to 16 nine-bit instructions written by a host or testbench. On `start`, it replays them in order onto the CPU's `instruction` input, either continuously or one per `step` pulse. Each issued word is qualified by a one-cycle `instr_valid` strobe. The downstream core must only commit state on cycles where `instr_valid` is high.

## Interface

Parameters:
- `IW`, 9: instruction width; matches the CPU opcode format `[8:6]` op, `[5:0]` operands.
- `DEPTH`, 16: program buffer entries; address width is 4.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `load_en`, in, 1: write `load_data` into `prog[load_addr]`.
- `load_addr`, in, 4: buffer write address.
- `load_data`, in, IW: instruction word to store.
- `prog_len`, in, 5: number of instructions to run, 0..16; sampled on `start`.
- `start`, in, 1: begin execution from address 0.
- `step_mode`, in, 1: 0 = issue one instruction every cycle; 1 = issue only on `step`. Sampled every cycle.
- `step`, in, 1: issue request in step mode; ignored when `step_mode` = 0.
- `halt`, in, 1: abort the run and return to IDLE.
- `instruction`, out, IW: last issued word (registered); feeds the CPU `instruction` input.
- `instr_valid`, out, 1: high for exactly one cycle per issued word.
- `pc`, out, 4: address of the next word to issue.
- `busy`, out, 1: high in state RUN.
- `done`, out, 1: program completed; sticky until the next `start`, `load_en`, or `halt`.

## Operation

- States are IDLE, RUN and DONE. Encoding is free; `busy` equals (state == RUN).
- **Reset** (`rst_n` = 0 at an edge):
  - state ← IDLE; `pc` ← 0; `instruction` ← 0; `instr_valid` ← 0; `done` ← 0.
  - All 16 buffer entries ← 0.
- **Load:** accepted only in IDLE or DONE.
  - `prog[load_addr]` ← `load_data`. In DONE, a load also clears `done` and moves to IDLE.
  - `load_en` in RUN is ignored; the buffer is unchanged.
- **Start:** accepted in IDLE or DONE.
  - `len` ← min(`prog_len`, 16); `pc` ← 0; `done` ← 0.
  - If `len` = 0: go to DONE and set `done` ← 1 with no issue.
  - Otherwise go to RUN. `start` in RUN is ignored.
- **Issue condition in RUN:** `step_mode` = 0, or `step` = 1.
  - On each qualifying edge: `instruction` ← `prog[pc]`; `instr_valid` ← 1; `pc` ← `pc` + 1 (4-bit wrap).
  - On a non-qualifying edge: `instr_valid` ← 0, and `instruction` and `pc` hold.
- **Completion:** on the edge that issues the word at index `len`−1:
  - state ← DONE; `done` ← 1.
  - `pc` wraps to 0 when `len` = 16, otherwise it equals `len`.
- `instr_valid` is 0 in every cycle not immediately following an issue edge. `instruction` holds its last value when not valid.
- **Halt:** from any state, at the edge where it is sampled:
  - state ← IDLE; `pc` ← 0; `instr_valid` ← 0; `done` ← 0.
  - `instruction` holds; the buffer is untouched.
- **Priority at one edge:** `rst_n` > `halt` > `start` > `load_en`.
  - `load_en` with `start` in the same IDLE cycle: both take effect. The write lands at that edge, before the first issue edge, so the first issue reads the new contents.
- **Step mode:** `step` held high issues one word per cycle, same as continuous mode. `step_mode` may change mid-run and takes effect at the next edge.

## Timing

- `start` sampled at edge E0 → `busy` = 1 after E0. In continuous mode, the first word is issued at E1.
- Continuous run of N words:
  - `instr_valid` is high in the N cycles following edges E1..EN.
  - `done` and DONE state are entered at EN, coinciding with the last valid cycle; `busy` falls at EN.
- Step mode: `step` sampled at edge Ek → that word is valid in the cycle after Ek. Latency is 1 cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- **Reset:** hold `rst_n` = 0 for 2 cycles, then release → all outputs 0, and `start` with `prog_len` = 0 gives `done` = 1 and no `instr_valid`.
- **Continuous run:**
  - Load `prog[0]` = 9'b111_0011_00 (r0←3), `prog[1]` = 9'b111_0101_01 (r1←5), `prog[2]` = 9'b000_0001_10 (r2←r0+r1); set `prog_len` = 3; pulse `start`.
  - → `instr_valid` high for 3 consecutive cycles carrying those words in order.
  - → `done` rises with the 3rd; `pc` = 3.
  - → A connected CPU shows r2 = 8.
- **Step mode:**
  - Same program with `step_mode` = 1 and `step` pulsed at cycles 5, 9, 10.
  - → Words are valid in cycles 6, 10, 11 only.
  - → `busy` stays high until cycle 11's issue edge.
- **Full buffer wrap:** load `prog[i]` = {3'b111, i[3:0], 2'b00} for all 16 entries; `prog_len` = 20 → exactly 16 issues, `done` = 1, `pc` = 0.
- **Halt mid-run:** continuous `prog_len` = 16, assert `halt` on the 5th issue cycle → `instr_valid` = 0 next cycle; state IDLE; `pc` = 0; `done` = 0.
- **Ignored inputs in RUN:** assert `load_en` with `load_addr` = 2 and `start` during RUN → the buffer is unchanged on rerun, and the sequence does not restart.
